// File: rtl/sha2_multiblock_engine.sv
// SHA-256 / SHA-224 compression engine: one padded 512-bit block per start,
// chaining into a running digest, with 1/2/4 rounds per clock and abort.
`timescale 1ns/1ps

module sha2_multiblock_engine #(
    parameter int ROUNDS_PER_CLK = 1
) (
    input  logic         clk_100mhz,
    input  logic         rstn_i,
    output logic         ready_o,
    input  logic         start_i,
    input  logic         first_i,
    input  logic         mode224_i,
    input  logic [511:0] vec_i,
    input  logic         abort_i,
    output logic         valid_o,
    output logic [255:0] hash_o
);

    localparam int CYCLES = 64 / ROUNDS_PER_CLK;

    generate
        if (ROUNDS_PER_CLK != 1 && ROUNDS_PER_CLK != 2 && ROUNDS_PER_CLK != 4) begin : g_bad_rounds
            $error("sha2_multiblock_engine: ROUNDS_PER_CLK must be 1, 2 or 4");
        end
    endgenerate

    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    localparam logic [255:0] IV256 =
        {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
         32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] IV224 =
        {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
         32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    localparam word_t K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t next_sched(input word_t w0, input word_t w1, input word_t w9, input word_t w14);
        return w0 + (rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3)) + w9
                  + (rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10));
    endfunction

    function automatic logic [255:0] sha_round(input logic [255:0] s, input word_t k, input word_t w);
        word_t a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    state_t        state, state_next;
    logic [511:0]  w_win;
    logic [255:0]  work;
    logic [255:0]  h_reg;
    logic          mode224;
    logic [6:0]    round_cnt;
    logic          round_last;
    logic [255:0]  st  [ROUNDS_PER_CLK+1];
    logic [511:0]  win [ROUNDS_PER_CLK+1];

    assign round_last = (round_cnt == 7'(ROUNDS_PER_CLK * (CYCLES - 1)));

    // The schedule is a sliding window holding W[t..t+15]; each round consumes
    // the head word and appends W[t+16], so rounds past 63 are simply unused.
    always_comb begin
        st[0]  = work;
        win[0] = w_win;
        for (int k = 0; k < ROUNDS_PER_CLK; k++) begin
            st[k+1]  = sha_round(st[k], K_ROM[round_cnt[5:0] + 6'(k)], win[k][511:480]);
            win[k+1] = {win[k][479:0],
                        next_sched(win[k][511:480], win[k][479:448], win[k][223:192], win[k][63:32])};
        end
    end

    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = ROUND;
            ROUND:   if (abort_i) state_next = IDLE;
                     else if (round_last) state_next = FINAL;
            FINAL:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state == IDLE);
        valid_o = (state == FINAL);
        hash_o  = mode224 ? {h_reg[255:32], 32'h0} : h_reg;
    end

    // The digest add happens on the edge leaving the last round so hash_o
    // already carries the new value during the valid_o cycle.
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            w_win     <= '0;
            work      <= '0;
            h_reg     <= IV256;
            mode224   <= 1'b0;
            round_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        w_win     <= vec_i;
                        round_cnt <= '0;
                        if (first_i) begin
                            work    <= mode224_i ? IV224 : IV256;
                            h_reg   <= mode224_i ? IV224 : IV256;
                            mode224 <= mode224_i;
                        end else begin
                            work <= h_reg;
                        end
                    end
                end
                ROUND: begin
                    if (!abort_i) begin
                        work      <= st[ROUNDS_PER_CLK];
                        w_win     <= win[ROUNDS_PER_CLK];
                        round_cnt <= round_cnt + 7'(ROUNDS_PER_CLK);
                        if (round_last) begin
                            for (int i = 0; i < 8; i++) begin
                                h_reg[255-32*i -: 32] <= h_reg[255-32*i -: 32] + st[ROUNDS_PER_CLK][255-32*i -: 32];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_multiblock_engine.sv
// Directed bench for sha2_multiblock_engine: known SHA-256/224 vectors on
// 1/2/4 rounds-per-clock instances, checked through an expected-result queue.
`timescale 1ns/1ps

module tb_sha2_multiblock_engine;

    localparam logic [255:0] IV256  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
    localparam logic [255:0] TWO256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_TWO1 =
        {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2 = {480'h0, 32'h000001c0};
    localparam int LAT [3] = '{65, 33, 17};

    typedef struct {
        logic [255:0] hash;
        int           due;
        int           inst;
        bit           chk;
    } sb_entry_t;

    logic         clk_100mhz = 1'b0;
    logic         rstn;
    logic         first, mode224, abort;
    logic [511:0] vec;
    logic         start [3];
    logic         ready [3];
    logic         valid [3];
    logic [255:0] hash  [3];

    int        cyc = 0;
    int        n_checks = 0;
    int        n_pass = 0;
    int        acc_cnt [3] = '{0, 0, 0};
    int        val_cnt [3] = '{0, 0, 0};
    int        acc0, val0;
    sb_entry_t sb_q [$];

    always #5 clk_100mhz = ~clk_100mhz;
    always @(posedge clk_100mhz) cyc <= cyc + 1;

    sha2_multiblock_engine #(.ROUNDS_PER_CLK(1)) u_dut_r1 (
        .clk_100mhz(clk_100mhz), .rstn_i(rstn), .ready_o(ready[0]), .start_i(start[0]),
        .first_i(first), .mode224_i(mode224), .vec_i(vec), .abort_i(abort),
        .valid_o(valid[0]), .hash_o(hash[0]));

    sha2_multiblock_engine #(.ROUNDS_PER_CLK(2)) u_dut_r2 (
        .clk_100mhz(clk_100mhz), .rstn_i(rstn), .ready_o(ready[1]), .start_i(start[1]),
        .first_i(first), .mode224_i(mode224), .vec_i(vec), .abort_i(abort),
        .valid_o(valid[1]), .hash_o(hash[1]));

    sha2_multiblock_engine #(.ROUNDS_PER_CLK(4)) u_dut_r4 (
        .clk_100mhz(clk_100mhz), .rstn_i(rstn), .ready_o(ready[2]), .start_i(start[2]),
        .first_i(first), .mode224_i(mode224), .vec_i(vec), .abort_i(abort),
        .valid_o(valid[2]), .hash_o(hash[2]));

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Drives one block request and records its expected digest and due cycle
    // once the engine is seen to accept it.
    task automatic applyStimulus(input int inst, input logic f, input logic m, input logic [511:0] blk,
                                 input logic [255:0] exp_hash, input bit chk, input bit hold);
        bit        acc = 1'b0;
        sb_entry_t e;
        @(posedge clk_100mhz); #1;
        first = f; mode224 = m; vec = blk; start[inst] = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk_100mhz);
            acc = ready[inst];
        end
        checkOutput("accept", {255'h0, acc}, 256'h1);
        if (acc) begin
            e.hash = exp_hash; e.due = cyc + LAT[inst]; e.inst = inst; e.chk = chk;
            sb_q.push_back(e);
        end
        if (!hold) begin
            @(posedge clk_100mhz); #1;
            start[inst] = 1'b0;
            abort = 1'b0;
            vec = {16{$urandom()}};
            first = 1'b0;
        end
        @(negedge clk_100mhz);
        checkOutput("ready_low_after_accept", {255'h0, ready[inst]}, 256'h0);
    endtask

    task automatic waitDone(input int inst);
        bit seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk_100mhz);
            seen = valid[inst];
        end
        checkOutput("done_seen", {255'h0, seen}, 256'h1);
        @(posedge clk_100mhz); #1;
        start[inst] = 1'b0;
        @(negedge clk_100mhz);
        checkOutput("ready_after_final", {255'h0, ready[inst]}, 256'h1);
        checkOutput("valid_single_pulse", {255'h0, valid[inst]}, 256'h0);
    endtask

    always @(negedge clk_100mhz) begin
        if (rstn) begin
            for (int i = 0; i < 3; i++) begin
                if (start[i] && ready[i]) acc_cnt[i]++;
                if (valid[i]) begin
                    val_cnt[i]++;
                    if (sb_q.size() == 0) begin
                        checkOutput("unexpected_valid", {255'h0, valid[i]}, 256'h0);
                    end else begin
                        sb_entry_t e;
                        e = sb_q.pop_front();
                        checkOutput("sb_instance", 256'(i), 256'(e.inst));
                        if (e.chk) checkOutput("sb_hash", hash[i], e.hash);
                        checkOutput("sb_latency", 256'(cyc), 256'(e.due));
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed no completion, required finish before 300000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn = 1'b0; first = 1'b0; mode224 = 1'b0; abort = 1'b0; vec = '0;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        repeat (3) @(negedge clk_100mhz);
        checkOutput("reset_ready", {255'h0, ready[0]}, 256'h1);
        checkOutput("reset_valid", {255'h0, valid[0]}, 256'h0);
        checkOutput("reset_hash", hash[0], IV256);
        #2 rstn = 1'b1;
        @(negedge clk_100mhz);
        checkOutput("post_reset_hash", hash[0], IV256);

        $display("[TB] SHA-256 abc, 1 round/clk");
        applyStimulus(0, 1'b1, 1'b0, BLK_ABC, ABC256, 1'b1, 1'b0);
        waitDone(0);

        $display("[TB] SHA-224 abc");
        applyStimulus(0, 1'b1, 1'b1, BLK_ABC, ABC224, 1'b1, 1'b0);
        waitDone(0);

        $display("[TB] two-block message, mode224 toggled on the chained block");
        applyStimulus(0, 1'b1, 1'b0, BLK_TWO1, '0, 1'b0, 1'b0);
        waitDone(0);
        applyStimulus(0, 1'b0, 1'b1, BLK_TWO2, TWO256, 1'b1, 1'b0);
        waitDone(0);
        checkOutput("two_block_hold", hash[0], TWO256);

        $display("[TB] start held high across a whole block");
        acc0 = acc_cnt[0]; val0 = val_cnt[0];
        applyStimulus(0, 1'b1, 1'b0, BLK_ABC, ABC256, 1'b1, 1'b1);
        waitDone(0);
        checkOutput("held_accepts", 256'(acc_cnt[0] - acc0), 256'h1);
        checkOutput("held_valids", 256'(val_cnt[0] - val0), 256'h1);

        $display("[TB] abort a chained block mid-round");
        applyStimulus(0, 1'b0, 1'b0, BLK_ABC, '0, 1'b0, 1'b0);
        void'(sb_q.pop_back());
        val0 = val_cnt[0];
        repeat (8) @(posedge clk_100mhz);
        #1 abort = 1'b1;
        @(posedge clk_100mhz);
        #1 abort = 1'b0;
        @(negedge clk_100mhz);
        checkOutput("abort_ready", {255'h0, ready[0]}, 256'h1);
        checkOutput("abort_hash", hash[0], ABC256);
        repeat (80) @(negedge clk_100mhz);
        checkOutput("abort_no_valid", 256'(val_cnt[0] - val0), 256'h0);
        applyStimulus(0, 1'b1, 1'b0, BLK_ABC, ABC256, 1'b1, 1'b0);
        waitDone(0);

        $display("[TB] abort together with start in idle");
        abort = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, BLK_ABC, ABC224, 1'b1, 1'b0);
        waitDone(0);

        $display("[TB] reset, then chain from the reset IV");
        @(posedge clk_100mhz);
        #3 rstn = 1'b0;
        #1 checkOutput("idle_reset_hash", hash[0], IV256);
        @(negedge clk_100mhz);
        #2 rstn = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, BLK_ABC, ABC256, 1'b1, 1'b0);
        waitDone(0);

        $display("[TB] asynchronous reset mid-round");
        applyStimulus(0, 1'b1, 1'b1, BLK_ABC, ABC224, 1'b1, 1'b0);
        repeat (20) @(posedge clk_100mhz);
        #3 rstn = 1'b0;
        #1;
        checkOutput("midreset_ready", {255'h0, ready[0]}, 256'h1);
        checkOutput("midreset_valid", {255'h0, valid[0]}, 256'h0);
        checkOutput("midreset_hash", hash[0], IV256);
        sb_q.delete();
        @(negedge clk_100mhz);
        #2 rstn = 1'b1;
        @(negedge clk_100mhz);
        checkOutput("after_midreset_hash", hash[0], IV256);

        $display("[TB] SHA-256 abc, 2 and 4 rounds/clk");
        applyStimulus(1, 1'b1, 1'b0, BLK_ABC, ABC256, 1'b1, 1'b0);
        waitDone(1);
        applyStimulus(2, 1'b1, 1'b0, BLK_ABC, ABC256, 1'b1, 1'b0);
        waitDone(2);
        applyStimulus(2, 1'b1, 1'b1, BLK_ABC, ABC224, 1'b1, 1'b0);
        waitDone(2);

        repeat (3) @(negedge clk_100mhz);
        checkOutput("scoreboard_drained", 256'(sb_q.size()), 256'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sha2_multiblock_engine.md
Name: sha2_multiblock_engine

Overview:
Parametrised SHA-2 (SHA-256 / SHA-224) compression engine that processes one pre-padded 512-bit block per start handshake and chains blocks into a running digest until the next first-block start. It generalises the single-block engine with selectable rounds-per-clock unrolling, SHA-224 mode, multi-block chaining, an on-the-fly 16-word message schedule and a synchronous abort. It sits between the AXI/register-bank message buffer (block source) and the result registers (hash sink).

Parameters:
ROUNDS_PER_CLK, 1, compression rounds per clock; legal values 1, 2, 4; any other value is an elaboration error.
CYCLES, 64/ROUNDS_PER_CLK, derived localparam giving round cycles per block.

Ports:
clk_100mhz  input  1  system clock; all logic on rising edge.
rstn_i  input  1  asynchronous active-low reset.
ready_o  output  1  high when the engine can accept start_i.
start_i  input  1  block request; accepted only when start_i && ready_o.
first_i  input  1  sampled at accept: 1 = load IV (new message), 0 = chain from the current digest.
mode224_i  input  1  sampled at accept only when first_i=1: 1 = SHA-224, 0 = SHA-256.
vec_i  input  512  padded block, word 0 in bits [511:480]; sampled at accept only.
abort_i  input  1  synchronous abort of the block in progress.
valid_o  output  1  one-cycle pulse: block done, hash_o updated.
hash_o  output  256  digest registers H0..H7, H0 in [255:224]; SHA-224 mode drives H0..H6 in [255:32] and 32'h0 in [31:0].

Behaviour:
- Reset (asynchronous, rstn_i=0): state=IDLE, ready_o=1, valid_o=0, mode=SHA-256, H0..H7 = SHA-256 IV (6a09e667 ... 5be0cd19), so hash_o = IV; round counter=0. Reset mid-block discards all progress.
- K constants are a combinational ROM indexed by round number, not reset-loaded registers.
- States: IDLE, ROUND, FINAL.
- IDLE: ready_o=1. On accept (cycle T): latch vec_i into the 16-entry W ring; load a..h from the IV of the selected mode if first_i=1, otherwise from the H registers; latch mode if first_i=1; round counter=0; ready_o goes 0 at T+1; next state ROUND.
- ROUND: each cycle performs ROUNDS_PER_CLK consecutive rounds as chained combinational logic. Round t<16 uses W[t] from the ring. Round t>=16 computes W[t] = W[t-16]+s0(W[t-15])+W[t-7]+s1(W[t-2]) and overwrites the oldest ring slot. All additions are mod 2^32. Counter advances by ROUNDS_PER_CLK; after CYCLES round cycles, next state FINAL.
- FINAL: Hi <= Hi + {a..h}[i] mod 2^32. SHA-224 with first_i=1 adds onto the SHA-224 IV (c1059ed8 ...). valid_o=1 for exactly this one cycle; ready_o=1 again on the next cycle; next state IDLE.
- Latency: accept at T, valid_o at T+CYCLES+1, ready_o at T+CYCLES+2; throughput is one block per CYCLES+2 cycles.
- start_i while ready_o=0 is ignored; no queuing.
- abort_i in ROUND: next cycle state=IDLE, ready_o=1, H unchanged, no valid_o. abort_i in IDLE or FINAL has no effect. abort_i and start_i together in IDLE: the start is accepted.
- mode224_i with first_i=0 is ignored; the chain keeps the latched mode.
- first_i=0 on the very first block after reset chains from the reset IV, which is identical to a SHA-256 first block.
- hash_o is stable except in the FINAL cycle, at accept with first_i=1 (H reloads to the selected IV), and on reset.

Test Plan:
- Reset, then check: ready_o=1, valid_o=0, hash_o = 6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19.
- SHA-256 "abc": vec_i = 61626380 followed by 14 zero words and 00000018, first_i=1, mode224_i=0. Require hash_o = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, with valid_o exactly CYCLES+1 cycles after accept. Run for ROUNDS_PER_CLK = 1, 2 and 4 (valid_o at T+65, T+33, T+17).
- SHA-224 "abc": same block with mode224_i=1. Require hash_o = 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7_00000000.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with first_i=1, block 2 with first_i=0 and mode224_i toggled to 1 (must be ignored). Require final hash_o = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- Hold start_i high throughout the "abc" run. Require no second accept before ready_o rises, and a single valid_o pulse per accept.
- Abort and reset mid-block: assert abort_i at round cycle 10. Require ready_o=1 next cycle, no valid_o, hash_o unchanged; the following "abc" run is correct. Then deassert rstn_i asynchronously mid-ROUND. Require immediate ready_o=1, valid_o=0 and hash_o = IV.
